shift_normalizer: RTL and testbench
===================================

Name: shift_normalizer

Overview:
- Multi-cycle normalizer: the inverse of the ALU barrel shifter.
- Given a 32-bit operand, it recovers the shift amount that normalizes it.
  - Unsigned mode: left-shifts until bit 31 is set.
  - Signed mode: left-shifts until bit 31 differs from bit 30.
- Returns the normalized value and the shift count, using one bit of shift per cycle.
- Sits beside the ALU as a leading-zero / redundant-sign-bit counter for CLZ-style instructions and soft-float normalization.
- Uses valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 32, operand width; the block supports only 32.
- CNT_WIDTH, 5, shift-count width, equal to log2(DATA_WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  32  operand.
- in_signed  input  1  0 = unsigned normalize, 1 = two's-complement normalize; sampled with in_data.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  normalized operand.
- out_shamt  output  5  left-shift count applied.
- out_zero  output  1  operand had no normalizable bit.

Behaviour:
- Reset (rst=1 at an edge): state goes to IDLE; out_valid=0, out_data=0, out_shamt=0, out_zero=0. in_ready=1 from the cycle after reset.
- Reset mid-operation discards the operand in flight; no result is produced for it.
- States and transitions:
  - IDLE: in_ready=1. On an edge with in_valid&&in_ready:
    - load the data register with in_data and the mode with in_signed;
    - clear the count;
    - set the zero flag if (unsigned and in_data==0) or (signed and in_data is all-0 or all-1);
    - go to SHIFT.
  - SHIFT: evaluate the stop condition each cycle.
    - Stop when any of: zero flag set; unsigned and data[31]==1; signed and data[31]!=data[30]; count==31 (safety cap).
    - If stop: go to DONE, out_valid=1.
    - Otherwise: data <= data<<1 (zero fill), count <= count+1.
  - DONE: out_valid=1. out_data, out_shamt and out_zero are held stable while out_ready=0. On an edge with out_valid&&out_ready, go to IDLE and out_valid=0.
- Latency: the accept edge is E0; out_valid rises after edge E0+shamt+1.
  - Range is 1 to 32 edges.
  - A zero operand takes 1 edge, with shamt=0 and out_data=in_data.
- Throughput: one operand in flight at a time.
  - No accept in the same cycle as a DONE handshake; in_ready rises the cycle after.
- in_valid while not in IDLE is ignored; the source must hold its operand until in_ready.
- Arithmetic invariant, for non-zero results:
  - unsigned: out_data >> out_shamt (logical) == in_data;
  - signed: out_data >>> out_shamt (arithmetic) == in_data.
- Ranges: unsigned shamt ∈ [0,31]; signed shamt ∈ [0,30]. The count never wraps.
- Outputs are registered; in_ready is decoded from state only.

Decomposition:
- Shared package holds:
  - DATA_WIDTH and CNT_WIDTH;
  - state encodings IDLE/SHIFT/DONE;
  - the existing shift-op encodings (LEFT=2'b00, LOGI_RIGHT=2'b10, ALGO_RIGHT=2'b11), which the bench uses for the inverse check.
- One natural combinational sub-module, norm_stop_detect: takes data and mode, produces the stop condition and the zero flag.
- The FSM, data register and count register stay in shift_normalizer.

Test Plan:
- Unsigned shift: unsigned 0x00010000 -> out_data=0x80000000, out_shamt=15, out_zero=0, out_valid after E0+16.
- Already normalized: unsigned 0x80000000 -> shamt=0, out_data=0x80000000, out_valid after E0+1. Signed 0x40000000 -> shamt=0.
- Signed, negative: 0xFFFF8000 -> out_data=0x80000000, shamt=16. Signed 0x00000001 -> out_data=0x40000000, shamt=30.
- Zero operands: unsigned 0x00000000 -> out_zero=1, shamt=0, out_data=0. Signed 0xFFFFFFFF -> out_zero=1, out_data=0xFFFFFFFF.
- Backpressure:
  - Stimulus: unsigned 0x00000F00 with out_ready=0 for 5 cycles after out_valid.
  - Required: outputs stable (0xF0000000, shamt=20); in_ready=0; a new in_valid is ignored.
  - On release: one handshake, then in_ready=1 the next cycle.
- Reset mid-SHIFT and cap, plus random sweep:
  - Stimulus: unsigned 0x00000001 with rst pulsed 10 cycles after accept.
  - Required: out_valid never rises, in_ready=1 after reset.
  - Then re-issue 0x00000001 -> shamt=31, out_data=0x80000000.
  - Random sweep: 1000 operands checked against the shifter invariant above.

Source files
------------

// File: rtl/shift_normalizer_pkg.sv
// ============================================================================
// Module      : shift_normalizer_pkg
// Description : Shared widths, normalizer FSM state encodings and the ALU
//               shift-op encodings used alongside the normalizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_normalizer_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 5;

  // Normalizer FSM states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Existing ALU barrel-shifter op encodings; the normalizer is the inverse
  // of LEFT, and LOGI_RIGHT / ALGO_RIGHT undo it for unsigned / signed mode.
  typedef enum logic [1:0] {
    LEFT       = 2'b00,
    LOGI_RIGHT = 2'b10,
    ALGO_RIGHT = 2'b11
  } shift_op_e;

endpackage

`default_nettype wire

// File: rtl/shift_normalizer_norm_stop_detect.sv
// ============================================================================
// Module      : norm_stop_detect
// Description : Combinational normalization test on one operand.
//   data        in  DATA_WIDTH  value under test
//   is_signed   in  1           0 = unsigned, 1 = two's complement
//   normalized  out 1           value is already normalized for its mode
//   zero        out 1           value has no normalizable bit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module norm_stop_detect #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  is_signed,
  output logic                  normalized,
  output logic                  zero
);

  logic w_all_zero;
  logic w_all_one;

  assign w_all_zero = (data == '0);
  assign w_all_one  = (data == '1);

  // Signed values are normalized once the sign bit and the next bit differ;
  // unsigned values once the top bit is set.
  assign normalized = is_signed ? (data[DATA_WIDTH-1] ^ data[DATA_WIDTH-2])
                                : data[DATA_WIDTH-1];

  // All-ones is the signed "zero": -1 carries no bits beyond the sign.
  assign zero = is_signed ? (w_all_zero | w_all_one) : w_all_zero;

endmodule

`default_nettype wire

// File: rtl/shift_normalizer.sv
// ============================================================================
// Module      : shift_normalizer
// Description : Multi-cycle leading-zero / redundant-sign-bit normalizer.
//               Shifts the operand left one bit per cycle until normalized
//               and reports the normalized value and the shift count.
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   operand offered
//   in_ready   out  1   block can accept (IDLE only)
//   in_data    in   32  operand
//   in_signed  in   1   0 = unsigned, 1 = two's-complement normalize
//   out_valid  out  1   result available
//   out_ready  in   1   consumer accepts the result
//   out_data   out  32  normalized operand
//   out_shamt  out  5   left-shift count applied
//   out_zero   out  1   operand had no normalizable bit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_normalizer #(
  parameter int DATA_WIDTH = shift_normalizer_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = shift_normalizer_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_shamt,
  output logic                  out_zero
);

  import shift_normalizer_pkg::*;

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_mode;
  logic                  r_zero;

  logic [DATA_WIDTH-1:0] w_det_data;
  logic                  w_det_mode;
  logic                  w_norm;
  logic                  w_zero;
  logic                  w_stop;

  // One detector serves both phases: in IDLE it classifies the incoming
  // operand (zero flag), afterwards it watches the working register.
  assign w_det_data = (r_state == IDLE) ? in_data   : r_data;
  assign w_det_mode = (r_state == IDLE) ? in_signed : r_mode;

  norm_stop_detect #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_stop_detect (
    .data       (w_det_data),
    .is_signed  (w_det_mode),
    .normalized (w_norm),
    .zero       (w_zero)
  );

  // The count cap keeps the counter from wrapping even if the detector
  // never fires.
  assign w_stop = r_zero | w_norm | (r_cnt == C_CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_mode  <= in_signed;
            r_cnt   <= '0;
            r_zero  <= w_zero;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_stop) begin
            r_state <= DONE;
          end else begin
            r_data <= {r_data[DATA_WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // All outputs come straight from registers; the working register and
  // count freeze in DONE, which holds the result stable under backpressure.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_data;
  assign out_shamt = r_cnt;
  assign out_zero  = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_shift_normalizer.sv
// ============================================================================
// Module      : tb_shift_normalizer
// Description : Scoreboard testbench for shift_normalizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_normalizer;

  import shift_normalizer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_shamt;
  logic        out_zero;

  shift_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shamt (out_shamt),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] din;
    bit          sgn;
    logic [31:0] d;
    int          sh;
    bit          z;
    int          e0;
  } exp_t;

  exp_t sb[$];

  // ---------------- reference model ----------------
  function automatic void ref_norm(input logic [31:0] d, input bit s,
                                   output logic [31:0] od, output int sh,
                                   output bit z);
    logic [31:0] m;
    int p;
    z  = s ? (d == 32'h0 || d == 32'hFFFF_FFFF) : (d == 32'h0);
    sh = 0;
    od = d;
    if (!z) begin
      // highest bit that carries information
      m = s ? (d ^ {32{d[31]}}) : d;
      p = -1;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      sh = s ? (30 - p) : (31 - p);
      od = d << sh;
    end
  endfunction

  function automatic logic [31:0] alu_shift(input shift_op_e op,
                                            input logic [31:0] a, input int n);
    case (op)
      LEFT:       return a << n;
      LOGI_RIGHT: return a >> n;
      ALGO_RIGHT: return $signed(a) >>> n;
      default:    return a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- out_ready driver ----------------
  bit manual_ready = 1'b0;
  bit manual_val   = 1'b1;
  bit stall_en     = 1'b0;

  always @(posedge clk) begin
    #1;
    if (manual_ready)  out_ready = manual_val;
    else if (stall_en) out_ready = ($urandom_range(0, 3) != 0);
    else               out_ready = 1'b1;
  end

  // ---------------- monitor ----------------
  bit   prev_v   = 1'b0;
  int   rise_cyc = 0;
  exp_t e;

  always @(negedge clk) begin
    if (out_valid && !prev_v) rise_cyc = cyc;
    prev_v = out_valid;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data",  out_data, e.d);
        chk("out_shamt", 32'(out_shamt), 32'(e.sh));
        chk("out_zero",  32'(out_zero), 32'(e.z));
        chk("latency",   32'(rise_cyc), 32'(e.e0 + e.sh + 1));
        if (!e.z) begin
          chk("inverse_shift",
              alu_shift(e.sgn ? ALGO_RIGHT : LOGI_RIGHT, out_data, int'(out_shamt)),
              e.din);
          chk("forward_shift", alu_shift(LEFT, e.din, int'(out_shamt)), out_data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] d, input bit s, input bit track);
    exp_t x;
    int   n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      return;
    end
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = s;
    if (track) begin
      x.din = d;
      x.sgn = s;
      ref_norm(d, s, x.d, x.sh, x.z);
      x.e0 = cyc + 1;
      sb.push_back(x);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=pending%0d required=0", sb.size());
    end
  endtask

  initial begin
    logic [31:0] d;
    bit          s;
    int          n;

    // reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  out_data, 32'h0);
    chk("rst_out_shamt", 32'(out_shamt), 32'h0);
    chk("rst_out_zero",  32'(out_zero), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // directed operands
    send(32'h0001_0000, 1'b0, 1'b1); wait_idle();
    send(32'h8000_0000, 1'b0, 1'b1); wait_idle();
    send(32'h4000_0000, 1'b1, 1'b1); wait_idle();
    send(32'hFFFF_8000, 1'b1, 1'b1); wait_idle();
    send(32'h0000_0001, 1'b1, 1'b1); wait_idle();
    send(32'h0000_0000, 1'b0, 1'b1); wait_idle();
    send(32'hFFFF_FFFF, 1'b1, 1'b1); wait_idle();
    send(32'h0000_0000, 1'b1, 1'b1); wait_idle();

    // backpressure
    manual_ready = 1'b1;
    manual_val   = 1'b0;
    @(negedge clk);
    send(32'h0000_0F00, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_rise", 32'(out_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_data",  out_data, 32'hF000_0000);
      chk("bp_hold_shamt", 32'(out_shamt), 32'd20);
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
      chk("bp_in_ready",   32'(in_ready), 32'h0);
      in_valid  = 1'b1;
      in_data   = 32'h1234_5678;
      in_signed = 1'b0;
      @(negedge clk);
    end
    in_valid   = 1'b0;
    manual_val = 1'b1;
    n = 0;
    while (out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_release_valid", 32'(out_valid), 32'h0);
    chk("bp_release_in_ready", 32'(in_ready), 32'h1);
    manual_ready = 1'b0;
    wait_idle();

    // reset in the middle of a shift
    send(32'h0000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk("midrst_no_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'h1);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    repeat (40) @(negedge clk);
    chk("midrst_still_quiet", 32'(out_valid), 32'h0);

    // count cap
    send(32'h0000_0001, 1'b0, 1'b1); wait_idle();

    // random sweep with random backpressure
    stall_en = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      s = $urandom_range(0, 1) != 0;
      d = $urandom;
      d = d >> $urandom_range(0, 31);
      if (s && $urandom_range(0, 1) != 0) d = ~d;
      if ($urandom_range(0, 20) == 0) d = (s && $urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
      send(d, s, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    stall_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
